conv_out_drain: RTL and testbench

//  Read-side drain for a conv layer's output activation memory. After compute, start

---
 rtl/conv_out_drain.sv | 239 +++++++++++++++++++++++
 tb/tb_conv_out_drain.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_drain.sv
// conv_out_drain: walks a conv layer's output activation memory in raster
// order ([entry][y][x], x fastest) and streams each word, tagged with its
// indices, over a valid/ready port. A 2-entry fall-through skid FIFO absorbs
// the fixed 1-cycle memory read latency when the consumer stalls.
module conv_out_drain #(
    parameter int NUM_OUTPUTS = 1,
    parameter int OUTPUT_DIM  = 3,
    parameter int DATA_SIZE   = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [15:0]          mem_rd_entry,
    output logic [15:0]          mem_rd_y,
    output logic [15:0]          mem_rd_x,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_SIZE-1:0] out_data,
    output logic [15:0]          out_entry,
    output logic [15:0]          out_y,
    output logic [15:0]          out_x,
    output logic                 out_last
);

    localparam logic [15:0] X_MAX = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0] Y_MAX = 16'(OUTPUT_DIM - 1);
    localparam logic [15:0] E_MAX = 16'(NUM_OUTPUTS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Read address counters (address of the next read to issue)
    logic [15:0] rd_entry;
    logic [15:0] rd_y;
    logic [15:0] rd_x;
    logic        rd_at_last;

    // Read whose data is on mem_rd_data this cycle, with its indices
    logic        inflight;
    logic [15:0] fl_entry;
    logic [15:0] fl_y;
    logic [15:0] fl_x;
    logic        fl_last;

    // Skid FIFO storage and bookkeeping
    logic [DATA_SIZE-1:0] fifo_data  [2];
    logic [15:0]          fifo_entry [2];
    logic [15:0]          fifo_y     [2];
    logic [15:0]          fifo_x     [2];
    logic                 fifo_last  [2];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           fifo_count;
    logic                 fifo_empty;
    logic [1:0]           occupancy;

    // Handshake/datapath controls
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 fire;
    logic                 head_valid;
    logic [DATA_SIZE-1:0] head_data;
    logic [15:0]          head_entry;
    logic [15:0]          head_y;
    logic [15:0]          head_x;
    logic                 head_last;

    // Read issue and head-of-line selection; an empty FIFO passes the
    // returning read straight through so the first beat costs no extra cycle
    always_comb begin
        rd_at_last = (rd_x == X_MAX) && (rd_y == Y_MAX) && (rd_entry == E_MAX);
        fifo_empty = (fifo_count == 2'd0);
        occupancy  = fifo_count + {1'b0, inflight};
        issue      = (state == READ) && (occupancy < 2'd2);

        head_valid = !fifo_empty || inflight;
        if (!fifo_empty) begin
            head_data  = fifo_data[rd_ptr];
            head_entry = fifo_entry[rd_ptr];
            head_y     = fifo_y[rd_ptr];
            head_x     = fifo_x[rd_ptr];
            head_last  = fifo_last[rd_ptr];
        end else begin
            head_data  = mem_rd_data;
            head_entry = fl_entry;
            head_y     = fl_y;
            head_x     = fl_x;
            head_last  = fl_last;
        end

        fire = head_valid && out_ready;
        pop  = !fifo_empty && out_ready;
        push = inflight && !(fifo_empty && out_ready);
    end

    // Port drive; everything reads as zero when nothing is being presented
    always_comb begin
        mem_rd_en    = issue;
        mem_rd_entry = issue ? rd_entry : 16'd0;
        mem_rd_y     = issue ? rd_y     : 16'd0;
        mem_rd_x     = issue ? rd_x     : 16'd0;

        out_valid = head_valid;
        out_data  = head_valid ? head_data  : '0;
        out_entry = head_valid ? head_entry : 16'd0;
        out_y     = head_valid ? head_y     : 16'd0;
        out_x     = head_valid ? head_x     : 16'd0;
        out_last  = head_valid && head_last;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issue && rd_at_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((fire && head_last) || (fifo_empty && !inflight)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Raster address counters: x fastest, then y, then entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_entry <= 16'd0;
            rd_y     <= 16'd0;
            rd_x     <= 16'd0;
        end else if (state == IDLE && start) begin
            rd_entry <= 16'd0;
            rd_y     <= 16'd0;
            rd_x     <= 16'd0;
        end else if (issue) begin
            if (rd_x == X_MAX) begin
                rd_x <= 16'd0;
                if (rd_y == Y_MAX) begin
                    rd_y     <= 16'd0;
                    rd_entry <= (rd_entry == E_MAX) ? 16'd0 : rd_entry + 16'd1;
                end else begin
                    rd_y <= rd_y + 16'd1;
                end
            end else begin
                rd_x <= rd_x + 16'd1;
            end
        end
    end

    // Track the outstanding read so its indices meet its data next cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            fl_entry <= 16'd0;
            fl_y     <= 16'd0;
            fl_x     <= 16'd0;
            fl_last  <= 1'b0;
        end else begin
            inflight <= issue;
            fl_entry <= rd_entry;
            fl_y     <= rd_y;
            fl_x     <= rd_x;
            fl_last  <= rd_at_last;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keeps the count
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage; contents are only meaningful where the pointers say so
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data[wr_ptr]  <= mem_rd_data;
            fifo_entry[wr_ptr] <= fl_entry;
            fifo_y[wr_ptr]     <= fl_y;
            fifo_x[wr_ptr]     <= fl_x;
            fifo_last[wr_ptr]  <= fl_last;
        end
    end

endmodule

// File: tb/tb_conv_out_drain.sv
// tb_conv_out_drain: drives two drain instances (2x3x3 and 1x1x1) against a
// memory model and compares every beat with a raster-order reference list.
module tb_conv_out_drain;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_rd_en, a_valid, a_ready, a_last;
    logic [15:0] a_rd_entry, a_rd_y, a_rd_x, a_entry, a_y, a_x;
    logic [63:0] a_rd_data, a_data;

    logic        b_start, b_busy, b_done, b_rd_en, b_valid, b_ready, b_last;
    logic [15:0] b_rd_entry, b_rd_y, b_rd_x, b_entry, b_y, b_x;
    logic [63:0] b_rd_data, b_data;

    conv_out_drain #(.NUM_OUTPUTS(2), .OUTPUT_DIM(3), .DATA_SIZE(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .busy(a_busy), .done(a_done),
        .mem_rd_en(a_rd_en), .mem_rd_entry(a_rd_entry), .mem_rd_y(a_rd_y),
        .mem_rd_x(a_rd_x), .mem_rd_data(a_rd_data), .out_valid(a_valid),
        .out_ready(a_ready), .out_data(a_data), .out_entry(a_entry), .out_y(a_y),
        .out_x(a_x), .out_last(a_last)
    );

    conv_out_drain #(.NUM_OUTPUTS(1), .OUTPUT_DIM(1), .DATA_SIZE(64)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .busy(b_busy), .done(b_done),
        .mem_rd_en(b_rd_en), .mem_rd_entry(b_rd_entry), .mem_rd_y(b_rd_y),
        .mem_rd_x(b_rd_x), .mem_rd_data(b_rd_data), .out_valid(b_valid),
        .out_ready(b_ready), .out_data(b_data), .out_entry(b_entry), .out_y(b_y),
        .out_x(b_x), .out_last(b_last)
    );

    localparam logic [63:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] ONE_D  = 64'h3FF0_0000_0000_0000;

    logic [63:0] mem_a [18];
    int          a_idx;

    assign a_idx = int'(a_rd_entry) * 9 + int'(a_rd_y) * 3 + int'(a_rd_x);

    // Memory models: data valid exactly one cycle after the read strobe
    always @(posedge clk) begin
        if (a_rd_en && a_idx < 18) a_rd_data <= mem_a[a_idx];
        else                       a_rd_data <= POISON;
        if (b_rd_en) b_rd_data <= ONE_D;
        else         b_rd_data <= POISON;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] cap_data[$];
    logic [15:0] cap_e[$], cap_y[$], cap_x[$];
    logic        cap_last[$];
    logic [63:0] exp_data[$];
    logic [15:0] exp_e[$], exp_y[$], exp_x[$];
    logic        exp_last[$];

    int first_fire, last_fire, rd_pulses, rd_pulses_early, done_pulses, stab_err;
    bit timeout;

    // Reference order: element i of a flat raster walk, decoded by div/mod
    task automatic build_expected(input int n_out, input int dim);
        exp_data.delete(); exp_e.delete(); exp_y.delete(); exp_x.delete(); exp_last.delete();
        for (int i = 0; i < n_out * dim * dim; i++) begin
            exp_data.push_back(mem_a[i]);
            exp_e.push_back(16'(i / (dim * dim)));
            exp_y.push_back(16'((i / dim) % dim));
            exp_x.push_back(16'(i % dim));
            exp_last.push_back(i == n_out * dim * dim - 1);
        end
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    // Runs dut_a from the cycle after start, applying a ready pattern and
    // recording beats, read strobes, done pulses and payload-hold violations.
    // mode: 0 ready=1, 1 toggling, 2 random, 3 stalled 10 cycles, 4 re-start at beat 4
    task automatic collect_a(input int mode, input int stop_beats, input int max_cycles);
        bit          hold = 0;
        bit          restarted = 0;
        bit          r;
        logic [63:0] hd;
        logic [15:0] he, hy, hx;
        logic        hl;
        int          done_cyc = -1;
        cap_data.delete(); cap_e.delete(); cap_y.delete(); cap_x.delete(); cap_last.delete();
        first_fire = -1; last_fire = -1; rd_pulses = 0; rd_pulses_early = 0;
        done_pulses = 0; stab_err = 0; timeout = 0;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            if (a_rd_en) begin
                rd_pulses++;
                if (cyc < 10) rd_pulses_early++;
            end
            if (a_done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (hold && (!a_valid || a_data !== hd || a_entry !== he || a_y !== hy ||
                         a_x !== hx || a_last !== hl)) stab_err++;
            case (mode)
                1:       r = (cyc % 2 == 0);
                2:       r = 1'($urandom_range(0, 1));
                3:       r = (cyc >= 10);
                default: r = 1'b1;
            endcase
            a_start = (mode == 4 && cap_data.size() == 4 && !restarted);
            if (a_start) restarted = 1;
            a_ready = r;
            if (a_valid && r) begin
                cap_data.push_back(a_data); cap_e.push_back(a_entry);
                cap_y.push_back(a_y); cap_x.push_back(a_x); cap_last.push_back(a_last);
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
            end
            hold = a_valid && !r;
            hd = a_data; he = a_entry; hy = a_y; hx = a_x; hl = a_last;
            if (stop_beats > 0 && cap_data.size() >= stop_beats) return;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                a_start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        a_start = 1'b0;
        timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; a_start = 0; b_start = 0; a_ready = 0; b_ready = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_busy !== 0 || a_done !== 0 || a_rd_en !== 0 || a_rd_entry !== 0 ||
            a_rd_y !== 0 || a_rd_x !== 0 || a_valid !== 0 || a_data !== 0 ||
            a_entry !== 0 || a_y !== 0 || a_x !== 0 || a_last !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_a: got busy=%0b done=%0b rd_en=%0b valid=%0b data=%h, expected all zero",
                     a_busy, a_done, a_rd_en, a_valid, a_data);
        end
        n_checks++;
        if (b_busy !== 0 || b_done !== 0 || b_rd_en !== 0 || b_valid !== 0 ||
            b_data !== 0 || b_last !== 0) begin
            n_fail++;
            $display("[TB] FAIL reset_b: got busy=%0b done=%0b rd_en=%0b valid=%0b data=%h, expected all zero",
                     b_busy, b_done, b_rd_en, b_valid, b_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 18; i++) mem_a[i] = 64'(i);
        build_expected(2, 3);
        a_ready = 1'b1;
        pulse_start_a();
        n_checks++;
        if (a_rd_en !== 1'b1 || a_valid !== 1'b0 || a_busy !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_latency_k1: got rd_en=%0b valid=%0b busy=%0b, expected 1 0 1",
                     a_rd_en, a_valid, a_busy);
        end
        collect_a(0, 0, 200);
        n_checks++;
        if (timeout) begin n_fail++; $display("[TB] FAIL b2b_timeout: got no done, expected done"); end
        n_checks++;
        if (first_fire != 1 || last_fire - first_fire != 17) begin
            n_fail++;
            $display("[TB] FAIL b2b_timing: got first=%0d span=%0d, expected first=1 span=17",
                     first_fire, last_fire - first_fire);
        end
        n_checks++;
        if (cap_data.size() != 18 || rd_pulses != 18) begin
            n_fail++;
            $display("[TB] FAIL b2b_count: got beats=%0d reads=%0d, expected 18 18", cap_data.size(), rd_pulses);
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== exp_data[i] || cap_e[i] !== exp_e[i] || cap_y[i] !== exp_y[i] ||
                cap_x[i] !== exp_x[i] || cap_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("[TB] FAIL b2b_beat%0d: got %h (%0d,%0d,%0d) last=%0b, expected %h (%0d,%0d,%0d) last=%0b",
                         i, cap_data[i], cap_e[i], cap_y[i], cap_x[i], cap_last[i],
                         exp_data[i], exp_e[i], exp_y[i], exp_x[i], exp_last[i]);
            end
        end
        n_checks++;
        if (done_pulses != 1 || a_busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL b2b_done: got done_pulses=%0d busy=%0b, expected 1 0", done_pulses, a_busy);
        end
    endtask

    task automatic test_backpressure(input int mode, input string name);
        build_expected(2, 3);
        pulse_start_a();
        collect_a(mode, 0, 400);
        n_checks++;
        if (timeout || cap_data.size() != 18 || done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL %s_count: got beats=%0d done_pulses=%0d timeout=%0b, expected 18 1 0",
                     name, cap_data.size(), done_pulses, timeout);
        end
        n_checks++;
        if (stab_err != 0) begin
            n_fail++;
            $display("[TB] FAIL %s_hold: got %0d unstable stall cycles, expected 0", name, stab_err);
        end
        if (mode == 3) begin
            n_checks++;
            if (rd_pulses_early > 2 || first_fire != 10) begin
                n_fail++;
                $display("[TB] FAIL %s_stall: got reads_in_stall=%0d first=%0d, expected <=2 and 10",
                         name, rd_pulses_early, first_fire);
            end
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== exp_data[i] || cap_e[i] !== exp_e[i] || cap_y[i] !== exp_y[i] ||
                cap_x[i] !== exp_x[i] || cap_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("[TB] FAIL %s_beat%0d: got %h (%0d,%0d,%0d) last=%0b, expected %h (%0d,%0d,%0d) last=%0b",
                         name, i, cap_data[i], cap_e[i], cap_y[i], cap_x[i], cap_last[i],
                         exp_data[i], exp_e[i], exp_y[i], exp_x[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 18; i++) mem_a[i] = {$urandom, $urandom};
            test_backpressure(2, "random");
        end
    endtask

    task automatic test_reset_mid();
        bit leaked = 0;
        for (int i = 0; i < 18; i++) mem_a[i] = 64'(i);
        build_expected(2, 3);
        pulse_start_a();
        collect_a(0, 5, 100);
        n_checks++;
        if (cap_data.size() != 5) begin
            n_fail++;
            $display("[TB] FAIL rstmid_pre: got %0d beats, expected 5", cap_data.size());
        end
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a_busy !== 0 || a_done !== 0 || a_rd_en !== 0 || a_rd_entry !== 0 || a_rd_y !== 0 ||
            a_rd_x !== 0 || a_valid !== 0 || a_data !== 0 || a_entry !== 0 || a_y !== 0 ||
            a_x !== 0 || a_last !== 0) begin
            n_fail++;
            $display("[TB] FAIL rstmid_zero: got busy=%0b rd_en=%0b valid=%0b data=%h, expected all zero",
                     a_busy, a_rd_en, a_valid, a_data);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (a_valid !== 0 || a_rd_en !== 0 || a_busy !== 0) leaked = 1;
        end
        n_checks++;
        if (leaked) begin
            n_fail++;
            $display("[TB] FAIL rstmid_quiet: got activity after reset, expected none until start");
        end
        pulse_start_a();
        collect_a(0, 0, 200);
        n_checks++;
        if (timeout || cap_data.size() != 18 || done_pulses != 1) begin
            n_fail++;
            $display("[TB] FAIL rstmid_count: got beats=%0d done_pulses=%0d, expected 18 1",
                     cap_data.size(), done_pulses);
        end
        for (int i = 0; i < cap_data.size() && i < exp_data.size(); i++) begin
            n_checks++;
            if (cap_data[i] !== exp_data[i] || cap_e[i] !== exp_e[i] || cap_y[i] !== exp_y[i] ||
                cap_x[i] !== exp_x[i] || cap_last[i] !== exp_last[i]) begin
                n_fail++;
                $display("[TB] FAIL rstmid_beat%0d: got %h (%0d,%0d,%0d), expected %h (%0d,%0d,%0d)",
                         i, cap_data[i], cap_e[i], cap_y[i], cap_x[i],
                         exp_data[i], exp_e[i], exp_y[i], exp_x[i]);
            end
        end
    endtask

    task automatic test_single();
        int          beats = 0;
        int          fire_cyc = -1;
        int          done_cyc = -1;
        int          dones = 0;
        logic [63:0] got_data = '0;
        logic [15:0] got_e = '1, got_y = '1, got_x = '1;
        logic        got_last = 0;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        n_checks++;
        if (b_rd_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL single_rd_en: got %0b, expected 1", b_rd_en);
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (b_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            b_ready = (cyc >= 3);
            if (b_valid && b_ready) begin
                beats++;
                fire_cyc = cyc;
                got_data = b_data; got_e = b_entry; got_y = b_y; got_x = b_x; got_last = b_last;
            end
            @(negedge clk);
        end
        n_checks++;
        if (beats != 1 || got_data !== ONE_D || got_last !== 1'b1 || got_e !== 0 || got_y !== 0 || got_x !== 0) begin
            n_fail++;
            $display("[TB] FAIL single_beat: got beats=%0d data=%h last=%0b (%0d,%0d,%0d), expected 1 %h 1 (0,0,0)",
                     beats, got_data, got_last, got_e, got_y, got_x, ONE_D);
        end
        n_checks++;
        if (dones != 1 || done_cyc != fire_cyc + 1) begin
            n_fail++;
            $display("[TB] FAIL single_done: got pulses=%0d at cyc %0d, expected 1 at cyc %0d",
                     dones, done_cyc, fire_cyc + 1);
        end
    endtask

    // Watchdog so a stuck design cannot hang the run
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence
    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure(1, "toggle");
        test_backpressure(3, "stall");
        test_backpressure(4, "restart");
        test_random();
        test_reset_mid();
        test_single();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
